// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// bexkat1Def: core typedefs shared by the bus interface and the memory arbiter.
// Rev 1.0
//------------------------------------------------------------------------------
package bexkat1Def;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef logic [WB_AW-1:0] addr_t;
  typedef logic [WB_DW-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INS   = 2'd1,
    S_DRAIN = 2'd2,
    S_DAT   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// if_wb: 32-bit pipelined Wishbone bundle with master and slave views.
// Rev 1.0
//------------------------------------------------------------------------------
interface if_wb;
  import bexkat1Def::*;

  logic       cyc;
  logic       stb;
  logic       we;
  logic [3:0] sel;
  addr_t      adr;
  word_t      dat_o;
  word_t      dat_i;
  logic       stall;
  logic       ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  dat_i, stall, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_o,
    output dat_i, stall, ack
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// mem_arbiter: shares one pipelined Wishbone bus between ifetch and data masters.
// Rev 1.0
//------------------------------------------------------------------------------
module mem_arbiter
  import bexkat1Def::*;
#(
  parameter int MAXOUT = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  if_wb.slave   ins,
  if_wb.slave   dat,
  if_wb.master  bus
);

  localparam int CW = $clog2(MAXOUT + 1);
  // Abandoned acks can pile up across several aborts, so give them headroom.
  localparam int SW = CW + 2;
  localparam logic [CW-1:0] C_MAX = CW'(MAXOUT);

  arb_state_t      state, state_next;
  logic [CW-1:0]   count, count_next;
  logic [SW-1:0]   stale, stale_next;
  logic [SW:0]     stale_sum;
  logic            ack_live;
  logic            full;
  logic            stb;
  logic            accept;
  logic            abort;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      count <= '0;
      stale <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      stale <= stale_next;
    end
  end

  always_comb begin
    // Acks owed to aborted transfers drain first and are never forwarded.
    ack_live = bus.ack && (stale == '0) && (count != '0);
    full     = (count == C_MAX) && !ack_live;

    stb       = 1'b0;
    bus.cyc   = 1'b0;
    bus.we    = ins.we;
    bus.sel   = ins.sel;
    bus.adr   = ins.adr;
    bus.dat_o = ins.dat_o;
    ins.stall = 1'b1;
    ins.ack   = 1'b0;
    dat.stall = 1'b1;
    dat.ack   = 1'b0;
    ins.dat_i = bus.dat_i;
    dat.dat_i = bus.dat_i;

    case (state)
      S_INS: begin
        bus.cyc   = ins.cyc;
        stb       = ins.stb && !full;
        ins.stall = bus.stall || full;
        ins.ack   = ack_live;
      end
      S_DRAIN: begin
        bus.cyc = 1'b1;
        ins.ack = ack_live;
      end
      S_DAT: begin
        bus.cyc   = dat.cyc;
        bus.we    = dat.we;
        bus.sel   = dat.sel;
        bus.adr   = dat.adr;
        bus.dat_o = dat.dat_o;
        stb       = dat.stb && !full;
        dat.stall = bus.stall || full;
        dat.ack   = ack_live;
      end
      default: ;
    endcase

    bus.stb = stb;
    accept  = stb && !bus.stall;

    count_next = count;
    if (accept && !ack_live)
      count_next = count + CW'(1);
    else if (!accept && ack_live)
      count_next = count - CW'(1);

    stale_next = stale;
    if (bus.ack && (stale != '0))
      stale_next = stale - SW'(1);

    state_next = state;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (dat.cyc)
          state_next = S_DAT;
        else if (ins.cyc)
          state_next = S_INS;
      end
      S_INS: begin
        if (!ins.cyc) begin
          abort      = 1'b1;
          state_next = dat.cyc ? S_DAT : S_IDLE;
        end else if (dat.cyc) begin
          state_next = ((count != '0) || accept) ? S_DRAIN : S_DAT;
        end
      end
      S_DRAIN: begin
        if (!ins.cyc) begin
          abort      = 1'b1;
          state_next = S_DAT;
        end else if (count_next == '0) begin
          state_next = S_DAT;
        end
      end
      S_DAT: begin
        if (!dat.cyc) begin
          abort      = 1'b1;
          state_next = ins.cyc ? S_INS : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    stale_sum = {1'b0, stale_next} + (SW+1)'(count_next);
    if (abort) begin
      stale_next = stale_sum[SW] ? '1 : stale_sum[SW-1:0];
      count_next = '0;
    end
  end

endmodule
`default_nettype wire
